// File: rtl/eth_rx_hdr_filter.sv
// ----------------------------------------------------------------------------
// eth_rx_hdr_filter
//
// Sits between the MAC RX AXIS output and the data-plane engine. It classifies
// each frame on its first beat by destination MAC and EtherType. Accepted
// frames are forwarded bit-exact, including tuser. All other frames are
// consumed silently. Saturating accept/drop counters feed the CSR block.
//
// Ports
//   clk, rst_n            single clock, asynchronous active-low reset
//   cfg_mac_addr[47:0]    own station MAC ([47:40] is the first octet on wire)
//   cfg_promisc           1 = skip the destination-MAC check
//   cnt_clr               synchronous clear of both counters (wins over +1)
//   s_axis_*              upstream AXIS (tdata/tkeep/tvalid/tready/tlast/tuser)
//   m_axis_*              downstream AXIS, registered through a 2-entry skid
//   cnt_accept/cnt_drop   saturating frame counters
//
// DATA_WIDTH must be at least 128 so that the 14-byte L2 header is in beat 0.
// ----------------------------------------------------------------------------
module eth_rx_hdr_filter #(
    parameter int          DATA_WIDTH = 128,
    parameter int          KEEP_WIDTH = DATA_WIDTH/8,
    parameter int          CNT_WIDTH  = 16,
    parameter logic [15:0] ETYPE_IPV4 = 16'h0800,
    parameter logic [15:0] ETYPE_ARP  = 16'h0806
) (
    input  logic                  clk,
    input  logic                  rst_n,

    input  logic [47:0]           cfg_mac_addr,
    input  logic                  cfg_promisc,
    input  logic                  cnt_clr,

    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic [KEEP_WIDTH-1:0] s_axis_tkeep,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    input  logic                  s_axis_tlast,
    input  logic                  s_axis_tuser,

    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tlast,
    output logic                  m_axis_tuser,

    output logic [CNT_WIDTH-1:0]  cnt_accept,
    output logic [CNT_WIDTH-1:0]  cnt_drop
);

    // One AXIS beat as carried through the skid buffer.
    typedef struct packed {
        logic [DATA_WIDTH-1:0] data;
        logic [KEEP_WIDTH-1:0] keep;
        logic                  last;
        logic                  user;
    } beat_t;

    typedef enum logic [1:0] {
        HDR  = 2'd0,
        PASS = 2'd1,
        DROP = 2'd2
    } state_t;

    state_t state;

    // ------------------------------------------------------------------
    // Header parse (only meaningful while state == HDR)
    // ------------------------------------------------------------------
    logic [47:0] hdr_dst;
    logic [15:0] hdr_etype;

    // Byte 0 on the wire is the most significant octet of the MAC address.
    for (genvar i = 0; i < 6; i++) begin : g_dst
        assign hdr_dst[8*(5-i) +: 8] = s_axis_tdata[8*i +: 8];
    end

    assign hdr_etype = {s_axis_tdata[8*12 +: 8], s_axis_tdata[8*13 +: 8]};

    logic keep_ok, dst_ok, etype_ok, hdr_accept;

    // tkeep is contiguous from bit 0, so 14+ valid bytes <=> low 14 bits set.
    assign keep_ok    = &s_axis_tkeep[13:0];
    assign dst_ok     = cfg_promisc || (hdr_dst == cfg_mac_addr) || (&hdr_dst);
    assign etype_ok   = (hdr_etype == ETYPE_IPV4) || (hdr_etype == ETYPE_ARP);
    assign hdr_accept = keep_ok && dst_ok && etype_ok;

    // ------------------------------------------------------------------
    // Input handshake
    // ------------------------------------------------------------------
    logic  rdy_en;      // holds tready low until the first clk after reset
    logic  out_vld;
    beat_t out_q;
    logic  skid_vld;
    beat_t skid_q;
    beat_t in_beat;

    logic s_hs, is_acc_beat, fwd, end_acc, end_drop;

    assign in_beat = '{data: s_axis_tdata, keep: s_axis_tkeep,
                       last: s_axis_tlast, user: s_axis_tuser};

    // DROP never writes the skid, so it may sink beats even when it is full.
    assign s_axis_tready = rdy_en && (!skid_vld || (state == DROP));
    assign s_hs          = s_axis_tvalid && s_axis_tready;

    // A beat belongs to an accepted frame if we are already passing, or if it
    // is the first beat and the header qualifies.
    assign is_acc_beat = (state == PASS) || ((state == HDR) && hdr_accept);
    assign fwd         = s_hs && is_acc_beat;
    assign end_acc     = s_hs && s_axis_tlast && is_acc_beat;
    assign end_drop    = s_hs && s_axis_tlast &&
                         ((state == DROP) || ((state == HDR) && !hdr_accept));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rdy_en <= 1'b0;
        else        rdy_en <= 1'b1;
    end

    // ------------------------------------------------------------------
    // Frame FSM: decision taken on the first beat and held to tlast.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= HDR;
        end else if (s_hs) begin
            case (state)
                // Single-beat frames finish here and stay in HDR.
                HDR:     if (!s_axis_tlast) state <= hdr_accept ? PASS : DROP;
                PASS:    if (s_axis_tlast)  state <= HDR;
                DROP:    if (s_axis_tlast)  state <= HDR;
                default: state <= HDR;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // 2-entry skid: out_q drives m_axis directly; skid_q catches the one beat
    // that can arrive in the cycle the output stalls. tready drops while
    // skid_q is occupied, so a forwarded beat never meets a full skid.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_vld  <= 1'b0;
            out_q    <= '0;
            skid_vld <= 1'b0;
            skid_q   <= '0;
        end else if (!out_vld || m_axis_tready) begin
            if (skid_vld) begin
                out_q    <= skid_q;
                out_vld  <= 1'b1;
                skid_vld <= 1'b0;
            end else if (fwd) begin
                out_q   <= in_beat;
                out_vld <= 1'b1;
            end else begin
                out_vld <= 1'b0;
            end
        end else if (fwd) begin
            skid_q   <= in_beat;
            skid_vld <= 1'b1;
        end
    end

    assign m_axis_tvalid = out_vld;
    assign m_axis_tdata  = out_q.data;
    assign m_axis_tkeep  = out_q.keep;
    assign m_axis_tlast  = out_q.last;
    assign m_axis_tuser  = out_q.user;

    // ------------------------------------------------------------------
    // Saturating statistics; clear wins over a same-cycle increment.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_accept <= '0;
            cnt_drop   <= '0;
        end else if (cnt_clr) begin
            cnt_accept <= '0;
            cnt_drop   <= '0;
        end else begin
            if (end_acc && !(&cnt_accept))
                cnt_accept <= cnt_accept + CNT_WIDTH'(1);
            if (end_drop && !(&cnt_drop))
                cnt_drop <= cnt_drop + CNT_WIDTH'(1);
        end
    end

endmodule

// File: tb/tb_eth_rx_hdr_filter.sv
module tb_eth_rx_hdr_filter;
    localparam int DW = 128;
    localparam int KW = 16;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [47:0]   cfg_mac_addr;
    logic          cfg_promisc;
    logic          cnt_clr;
    logic [DW-1:0] s_axis_tdata;
    logic [KW-1:0] s_axis_tkeep;
    logic          s_axis_tvalid;
    logic          s_axis_tready;
    logic          s_axis_tlast;
    logic          s_axis_tuser;
    logic [DW-1:0] m_axis_tdata;
    logic [KW-1:0] m_axis_tkeep;
    logic          m_axis_tvalid;
    logic          m_axis_tready;
    logic          m_axis_tlast;
    logic          m_axis_tuser;
    logic [CW-1:0] cnt_accept;
    logic [CW-1:0] cnt_drop;

    always #5 clk = ~clk;

    eth_rx_hdr_filter dut (
        .clk(clk), .rst_n(rst_n),
        .cfg_mac_addr(cfg_mac_addr), .cfg_promisc(cfg_promisc), .cnt_clr(cnt_clr),
        .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep),
        .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
        .s_axis_tlast(s_axis_tlast), .s_axis_tuser(s_axis_tuser),
        .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep),
        .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
        .m_axis_tlast(m_axis_tlast), .m_axis_tuser(m_axis_tuser),
        .cnt_accept(cnt_accept), .cnt_drop(cnt_drop)
    );

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- reference model ----------------
    typedef struct {
        logic [DW-1:0] d;
        logic [KW-1:0] k;
        logic          l;
        logic          u;
        int            c;
    } exp_t;

    exp_t expq[$];
    int   m_acc = 0;
    int   m_drop = 0;
    bit   cur_acc;
    bit   chk_lat = 0;
    int   stall_cnt = 0;
    int   mon_beats = 0;

    function automatic bit model_accept(logic [DW-1:0] d, logic [KW-1:0] k,
                                        logic [47:0] mac, bit pr);
        logic [7:0]  b[16];
        logic [47:0] dst;
        logic [15:0] et;
        int          nbytes;
        bit          run;
        nbytes = 0;
        run = 1;
        for (int i = 0; i < 16; i++) begin
            b[i] = d[8*i +: 8];
            if (run && k[i]) nbytes++;
            else run = 0;
        end
        dst = {b[0], b[1], b[2], b[3], b[4], b[5]};
        et  = {b[12], b[13]};
        if (nbytes < 14) return 0;
        if (!(pr || dst == mac || dst == 48'hFFFF_FFFF_FFFF)) return 0;
        return (et == 16'h0800) || (et == 16'h0806);
    endfunction

    function automatic logic [DW-1:0] mk_b0(logic [47:0] dst, logic [15:0] et);
        logic [DW-1:0] d;
        d = {$urandom, $urandom, $urandom, $urandom};
        for (int i = 0; i < 6; i++) d[8*i +: 8] = dst[8*(5-i) +: 8];
        d[96 +: 8]  = et[15:8];
        d[104 +: 8] = et[7:0];
        return d;
    endfunction

    // ---------------- downstream ready generator ----------------
    int   bp_mode = 0;     // 0: rdy_base, 1: toggle every 3 clks, 2: random
    logic rdy_base = 1'b1;
    int   bp_cnt = 0;
    initial begin
        m_axis_tready = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (bp_mode == 1) begin
                bp_cnt++;
                if (bp_cnt % 3 == 0) m_axis_tready = ~m_axis_tready;
            end else if (bp_mode == 2) begin
                m_axis_tready = 1'($urandom_range(0, 1));
            end else begin
                m_axis_tready = rdy_base;
            end
        end
    end

    // ---------------- output monitor / scoreboard ----------------
    logic          stalled = 1'b0;
    logic [DW-1:0] hd;
    logic [KW-1:0] hk;
    logic          hl, hu;
    exp_t          mon_e;

    always @(negedge clk) begin
        if (rst_n !== 1'b1) begin
            stalled = 1'b0;
        end else begin
            if (stalled) begin
                checks++;
                if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== hd || m_axis_tkeep !== hk ||
                    m_axis_tlast !== hl || m_axis_tuser !== hu) begin
                    failures++;
                    $display("FAIL stall_stable: got v=%b d=%h k=%h, held d=%h k=%h",
                             m_axis_tvalid, m_axis_tdata, m_axis_tkeep, hd, hk);
                end
            end
            if (m_axis_tvalid === 1'b1 && m_axis_tready === 1'b1) begin
                checks++;
                mon_beats++;
                if (expq.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_beat: got d=%h k=%h, expected no beat",
                             m_axis_tdata, m_axis_tkeep);
                end else begin
                    mon_e = expq.pop_front();
                    if (m_axis_tdata !== mon_e.d || m_axis_tkeep !== mon_e.k ||
                        m_axis_tlast !== mon_e.l || m_axis_tuser !== mon_e.u) begin
                        failures++;
                        $display("FAIL beat: got d=%h k=%h l=%b u=%b, exp d=%h k=%h l=%b u=%b",
                                 m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tuser,
                                 mon_e.d, mon_e.k, mon_e.l, mon_e.u);
                    end
                    if (chk_lat && cyc != mon_e.c) begin
                        failures++;
                        $display("FAIL latency: out after input cyc %0d at cyc %0d, need 1 clk",
                                 mon_e.c, cyc + 1);
                    end
                end
            end
            stalled = (m_axis_tvalid === 1'b1) && (m_axis_tready !== 1'b1);
            hd = m_axis_tdata; hk = m_axis_tkeep; hl = m_axis_tlast; hu = m_axis_tuser;
        end
    end

    // ---------------- drivers ----------------
    task automatic send_beat(input logic [DW-1:0] d, input logic [KW-1:0] k,
                             input logic l, input logic u, input bit first, input bit gap);
        bit hs;
        int n;
        if (gap && $urandom_range(0, 3) == 0) begin
            s_axis_tvalid = 1'b0;
            @(posedge clk); #1;
        end
        s_axis_tdata = d; s_axis_tkeep = k; s_axis_tlast = l; s_axis_tuser = u;
        s_axis_tvalid = 1'b1;
        n = 0;
        forever begin
            @(negedge clk);
            hs = (s_axis_tready === 1'b1);
            @(posedge clk); #1;
            if (hs) break;
            stall_cnt++;
            n++;
            if (n > 2000) begin
                checks++; failures++;
                $display("FAIL hs_timeout: tready=%b, need 1", s_axis_tready);
                return;
            end
        end
        if (first) cur_acc = model_accept(d, k, cfg_mac_addr, cfg_promisc);
        if (cur_acc) expq.push_back('{d, k, l, u, cyc});
        if (l) begin
            if (cur_acc) begin if (m_acc < 65535) m_acc++; end
            else begin if (m_drop < 65535) m_drop++; end
        end
    endtask

    task automatic send_frame(input int nb, input logic [DW-1:0] b0,
                              input logic [KW-1:0] lastk, input logic user, input bit gap);
        logic [DW-1:0] d;
        for (int i = 0; i < nb; i++) begin
            d = (i == 0) ? b0 : {$urandom, $urandom, $urandom, $urandom};
            send_beat(d, (i == nb-1) ? lastk : 16'hFFFF, i == nb-1,
                      (i == nb-1) ? user : 1'($urandom_range(0, 1)), i == 0, gap);
        end
        s_axis_tvalid = 1'b0;
    endtask

    task automatic wait_drain(input string nm);
        int n = 0;
        while ((expq.size() != 0 || m_axis_tvalid === 1'b1) && n < 500) begin
            @(posedge clk); #1; n++;
        end
        repeat (2) begin @(posedge clk); #1; end
        checks++;
        if (expq.size() != 0 || m_axis_tvalid !== 1'b0) begin
            failures++;
            $display("FAIL %s_drain: pending=%0d tvalid=%b, need 0/0", nm, expq.size(), m_axis_tvalid);
        end
    endtask

    task automatic check_cnt(input string nm);
        checks++;
        if (cnt_accept !== CW'(m_acc) || cnt_drop !== CW'(m_drop)) begin
            failures++;
            $display("FAIL %s_cnt: got acc=%0d drop=%0d, need acc=%0d drop=%0d",
                     nm, cnt_accept, cnt_drop, m_acc, m_drop);
        end
    endtask

    task automatic pulse_clr();
        cnt_clr = 1'b1;
        @(posedge clk); #1;
        cnt_clr = 1'b0;
        m_acc = 0; m_drop = 0;
    endtask

    task automatic check_outs_zero(input string nm);
        checks++;
        if (m_axis_tvalid !== 1'b0 || m_axis_tdata !== '0 || m_axis_tkeep !== '0 ||
            m_axis_tlast !== 1'b0 || m_axis_tuser !== 1'b0 || s_axis_tready !== 1'b0 ||
            cnt_accept !== '0 || cnt_drop !== '0) begin
            failures++;
            $display("FAIL %s: got v=%b d=%h k=%h l=%b u=%b rdy=%b acc=%0d drop=%0d, need all 0",
                     nm, m_axis_tvalid, m_axis_tdata, m_axis_tkeep, m_axis_tlast,
                     m_axis_tuser, s_axis_tready, cnt_accept, cnt_drop);
        end
    endtask

    localparam logic [127:0] TP_B0 = 128'h00050008F85ABFE5363A83B59434E6A2;

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_outs_zero("reset_state");
        rst_n = 1'b1;
        #1;
        checks++;
        if (s_axis_tready !== 1'b0) begin
            failures++;
            $display("FAIL ready_before_clk: got %b, need 0", s_axis_tready);
        end
        @(posedge clk); #1;
        checks++;
        if (s_axis_tready !== 1'b1) begin
            failures++;
            $display("FAIL ready_after_release: got %b, need 1", s_axis_tready);
        end
    endtask

    task automatic test_forward();
        cfg_mac_addr = 48'hA2E6_3494_B583; cfg_promisc = 1'b0; rdy_base = 1'b1;
        @(posedge clk); #1;
        chk_lat = 1; stall_cnt = 0; mon_beats = 0;
        send_frame(11, TP_B0, 16'h03FF, 1'b0, 0);
        wait_drain("forward");
        chk_lat = 0;
        checks++;
        if (mon_beats != 11 || stall_cnt != 0) begin
            failures++;
            $display("FAIL forward_beats: got beats=%0d stalls=%0d, need 11/0", mon_beats, stall_cnt);
        end
        check_cnt("forward");
    endtask

    task automatic test_mac_mismatch();
        pulse_clr();
        cfg_mac_addr = 48'h0200_0000_0001; cfg_promisc = 1'b0; rdy_base = 1'b0;
        @(posedge clk); #1;
        stall_cnt = 0;
        send_frame(11, TP_B0, 16'h03FF, 1'b0, 0);
        checks++;
        if (stall_cnt != 0 || m_axis_tvalid !== 1'b0) begin
            failures++;
            $display("FAIL mismatch_drop: got stalls=%0d tvalid=%b, need 0/0", stall_cnt, m_axis_tvalid);
        end
        check_cnt("mismatch");
        rdy_base = 1'b1; cfg_promisc = 1'b1;
        send_frame(11, TP_B0, 16'h03FF, 1'b1, 0);
        wait_drain("promisc");
        check_cnt("promisc");
        cfg_promisc = 1'b0;
    endtask

    task automatic test_etype();
        pulse_clr();
        send_frame(4, mk_b0(48'hFFFF_FFFF_FFFF, 16'h0806), 16'h00FF, 1'b0, 1);
        send_frame(4, mk_b0(48'hFFFF_FFFF_FFFF, 16'h86DD), 16'h00FF, 1'b0, 1);
        wait_drain("etype");
        check_cnt("etype");
    endtask

    task automatic test_runt();
        pulse_clr();
        cfg_mac_addr = 48'hA2E6_3494_B583;
        send_frame(1, TP_B0, 16'h0FFF, 1'b0, 0);    // 12 bytes: dropped
        send_frame(1, TP_B0, 16'h3FFF, 1'b0, 0);    // exactly 14 bytes: accepted
        send_frame(3, TP_B0, 16'h0001, 1'b1, 0);
        wait_drain("runt");
        check_cnt("runt");
    endtask

    task automatic test_back_to_back();
        pulse_clr();
        mon_beats = 0; bp_cnt = 0; bp_mode = 1;
        for (int f = 0; f < 4; f++) send_frame(11, mk_b0(48'hA2E6_3494_B583, 16'h0800), 16'h03FF, 1'b0, 0);
        wait_drain("b2b");
        bp_mode = 0;
        checks++;
        if (mon_beats != 44) begin
            failures++;
            $display("FAIL b2b_beats: got %0d, need 44", mon_beats);
        end
        check_cnt("b2b");
    endtask

    task automatic test_random();
        logic [47:0] dst;
        logic [15:0] et;
        logic [16:0] km;
        int nb, nbytes;
        pulse_clr();
        bp_mode = 2;
        for (int f = 0; f < 40; f++) begin
            cfg_promisc = ($urandom_range(0, 3) == 0);
            case ($urandom_range(0, 2))
                0:       dst = cfg_mac_addr;
                1:       dst = 48'hFFFF_FFFF_FFFF;
                default: dst = {$urandom, $urandom};
            endcase
            case ($urandom_range(0, 3))
                0:       et = 16'h0800;
                1:       et = 16'h0806;
                2:       et = 16'h86DD;
                default: et = 16'($urandom);
            endcase
            nb = $urandom_range(1, 5);
            nbytes = $urandom_range((nb == 1) ? 11 : 1, 16);
            km = (17'd1 << nbytes) - 17'd1;
            send_frame(nb, mk_b0(dst, et), km[15:0], 1'($urandom_range(0, 1)), 1);
        end
        bp_mode = 0; rdy_base = 1'b1; cfg_promisc = 1'b0;
        wait_drain("random");
        check_cnt("random");
    endtask

    task automatic test_reset_midframe();
        pulse_clr();
        cfg_mac_addr = 48'hA2E6_3494_B583;
        for (int i = 0; i < 5; i++)
            send_beat((i == 0) ? TP_B0 : {$urandom, $urandom, $urandom, $urandom},
                      16'hFFFF, 1'b0, 1'b0, i == 0, 0);
        rst_n = 1'b0;
        #1;
        check_outs_zero("reset_midframe");
        s_axis_tvalid = 1'b0;
        expq.delete();
        m_acc = 0; m_drop = 0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        send_frame(4, TP_B0, 16'h07FF, 1'b0, 0);
        wait_drain("post_reset");
        check_cnt("post_reset");
    endtask

    task automatic test_saturation();
        pulse_clr();
        s_axis_tdata = TP_B0; s_axis_tkeep = 16'h0FFF; s_axis_tlast = 1'b1; s_axis_tuser = 1'b0;
        checks++;
        if (s_axis_tready !== 1'b1) begin
            failures++;
            $display("FAIL sat_ready: got %b, need 1", s_axis_tready);
        end
        s_axis_tvalid = 1'b1;
        repeat (65537) @(posedge clk);
        #1;
        s_axis_tvalid = 1'b0;
        m_drop = 65535;
        check_cnt("saturate");
        cnt_clr = 1'b1; s_axis_tvalid = 1'b1;
        @(posedge clk); #1;
        cnt_clr = 1'b0; s_axis_tvalid = 1'b0;
        m_drop = 0; m_acc = 0;
        check_cnt("clr_priority");
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        cfg_mac_addr = 48'hA2E6_3494_B583; cfg_promisc = 1'b0; cnt_clr = 1'b0;
        s_axis_tdata = '0; s_axis_tkeep = '0; s_axis_tvalid = 1'b0;
        s_axis_tlast = 1'b0; s_axis_tuser = 1'b0;
        test_reset();
        test_forward();
        test_mac_mismatch();
        test_etype();
        test_runt();
        test_back_to_back();
        test_random();
        test_reset_midframe();
        test_saturation();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
